// File: rtl/dbg_bridge_pkg.sv
// Shared widths, IR codes and the command entry type for the debug command bridge.
// Entry layout gains a timestamp field when DBG_CMD_BRIDGE_TIMESTAMP_EN is defined.
package dbg_bridge_pkg;

    localparam int SR_W_DEF = 38;
    localparam int IR_W_DEF = 2;
    localparam int TS_W_DEF = 16;

    localparam logic [IR_W_DEF-1:0] IR_MONITOR = 2'd0;
    localparam logic [IR_W_DEF-1:0] IR_BREAK   = 2'd1;
    localparam logic [IR_W_DEF-1:0] IR_TRACE   = 2'd2;
    localparam logic [IR_W_DEF-1:0] IR_CTRL    = 2'd3;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] data;
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
        logic [TS_W_DEF-1:0] ts;
`endif
    } cmd_entry_t;

    // Pointer carries one extra wrap bit so that full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dbg_strobe_sync.sv
// Multi-flop synchroniser for a JTAG-domain strobe level, followed by a
// one-cycle rising-edge pulse generator in the system clock domain.
module dbg_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/debug_slave_cmd_bridge.sv
// Debug slave command bridge: synchronises update-IR/DR strobes and queues {ir, data}
// commands behind a valid/ready interface. Define DBG_CMD_BRIDGE_TIMESTAMP_EN for cmd_ts.
module debug_slave_cmd_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
    , parameter int TS_W      = TS_W_DEF
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SR_W-1:0]               sr,
    input  logic [IR_W-1:0]               ir_in,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [SR_W-1:0]               cmd_data,
    output logic [2**IR_W-1:0]            cmd_act,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
    , output logic [TS_W-1:0]             cmd_ts
`endif
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int IDX_W = PTR_W - 1;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
    } entry_t;

    logic             udr_pulse, uir_pulse;
    logic [IR_W-1:0]  ir_latched_q, ir_latched_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] level;
    logic             full, push, pop;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           wr_entry, head;
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_q, ts_d;
`endif

    dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .pulse    (udr_pulse)
    );

    dbg_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .pulse    (uir_pulse)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        level     = wr_ptr_q - rd_ptr_q;
        full      = (level == PTR_W'(FIFO_DEPTH));
        cmd_valid = (level != '0);
        pop       = cmd_valid & cmd_ready;
        // A pop in the same cycle frees the slot, so a full queue still accepts the push.
        push      = udr_pulse & (~full | pop);

        ir_latched_d = uir_pulse ? ir_in : ir_latched_q;
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);

        overflow_d = overflow_q;
        if (ovf_clr)
            overflow_d = 1'b0;
        else if (udr_pulse && full && !pop)
            overflow_d = 1'b1;

        wr_entry      = '0;
        wr_entry.ir   = ir_latched_q;
        wr_entry.data = sr;
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
        wr_entry.ts   = ts_q;
        ts_d          = ts_q + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_latched_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
            ts_q         <= '0;
`endif
        end else begin
            ir_latched_q <= ir_latched_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
            ts_q         <= ts_d;
`endif
        end
    end

    // NOTE: storage is not reset; pointer reset empties the queue and outputs are gated by cmd_valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_entry;
    end

    always_comb begin
        head    = cmd_valid ? mem_q[rd_ptr_q[IDX_W-1:0]] : '0;
        cmd_act = '0;
        for (int i = 0; i < 2**IR_W; i++)
            cmd_act[i] = cmd_valid && (head.ir == IR_W'(i));
    end

    assign cmd_ir     = head.ir;
    assign cmd_data   = head.data;
    assign fifo_level = level;
    assign overflow   = overflow_q;
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
    assign cmd_ts     = head.ts;
`endif

endmodule

// File: tb/tb_debug_slave_cmd_bridge.sv
// Directed + randomised bench for debug_slave_cmd_bridge against a queue-based reference model.
// Timestamp checks are active when DBG_CMD_BRIDGE_TIMESTAMP_EN is defined.
module tb_debug_slave_cmd_bridge;
    import dbg_bridge_pkg::*;

    localparam int SR_W  = 38;
    localparam int IR_W  = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [SR_W-1:0]   sr;
    logic [IR_W-1:0]   ir_in;
    logic              vs_udr, vs_uir;
    logic              cmd_valid, cmd_ready;
    logic [IR_W-1:0]   cmd_ir;
    logic [SR_W-1:0]   cmd_data;
    logic [3:0]        cmd_act;
    logic [2:0]        fifo_level;
    logic              overflow, ovf_clr;
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
    logic [15:0]       cmd_ts;
`endif

    debug_slave_cmd_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .sr         (sr),
        .ir_in      (ir_in),
        .vs_udr     (vs_udr),
        .vs_uir     (vs_uir),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .cmd_act    (cmd_act),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
        , .cmd_ts   (cmd_ts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
        logic [15:0]     ts;
    } m_entry_t;

    m_entry_t    q[$];
    logic [1:0]  m_ir;
    bit          m_ovf;
    logic [15:0] m_ts;
    int          total = 0;
    int          bad   = 0;

    // Reference free-running timestamp: cycles since reset release, wrapping at 16 bits.
    always @(posedge clk) m_ts <= reset ? 16'd0 : m_ts + 16'd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [3:0] e_act;
        check({tag, ".valid"}, 64'(cmd_valid), 64'(q.size() != 0));
        check({tag, ".level"}, 64'(fifo_level), 64'(q.size()));
        check({tag, ".ovf"},   64'(overflow),   64'(m_ovf));
        if (q.size() != 0) begin
            e_act = 4'b0001 << q[0].ir;
            check({tag, ".ir"},   64'(cmd_ir),   64'(q[0].ir));
            check({tag, ".data"}, 64'(cmd_data), 64'(q[0].data));
            check({tag, ".act"},  64'(cmd_act),  64'(e_act));
`ifdef DBG_CMD_BRIDGE_TIMESTAMP_EN
            check({tag, ".ts"},   64'(cmd_ts),   64'(q[0].ts));
`endif
        end else begin
            check({tag, ".ir0"},   64'(cmd_ir),   64'd0);
            check({tag, ".data0"}, 64'(cmd_data), 64'd0);
            check({tag, ".act0"},  64'(cmd_act),  64'd0);
        end
    endtask

    // One update-DR strobe; optional same-cycle pop, overflow clear, IR update and extended hold.
    task automatic do_udr(input logic [SR_W-1:0] d, input bit pop_too, input bit clr_too,
                          input bit uir_too, input logic [1:0] ir_val, input int hold);
        m_entry_t e;
        sr     = d;
        vs_udr = 1'b1;
        if (uir_too) begin
            ir_in  = ir_val;
            vs_uir = 1'b1;
        end
        step();
        step();
        e.ir = m_ir; e.data = d; e.ts = m_ts;
        cmd_ready = pop_too;
        ovf_clr   = clr_too;
        step();
        cmd_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (hold) step();
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        repeat (3) step();
        if (pop_too && q.size() != 0) void'(q.pop_front());
        if (q.size() < DEPTH) q.push_back(e);
        else                  m_ovf = 1'b1;
        if (clr_too) m_ovf = 1'b0;
        if (uir_too) m_ir = ir_val;
    endtask

    task automatic do_uir(input logic [1:0] v);
        ir_in  = v;
        vs_uir = 1'b1;
        repeat (3) step();
        vs_uir = 1'b0;
        repeat (3) step();
        m_ir = v;
    endtask

    task automatic do_pop();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic do_clr();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
    endtask

    function automatic logic [SR_W-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        reset = 1'b1; sr = '0; ir_in = '0; vs_udr = 1'b0; vs_uir = 1'b0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        m_ir = '0; m_ovf = 1'b0;
        step(); step();
        check_state("reset");
        reset = 1'b0;
        step();

        // IR update then first command, with exact push latency.
        do_uir(IR_TRACE);
        sr = 38'h2_DEAD_BEEF;
        vs_udr = 1'b1;
        step();
        step();
        check("lat_early", 64'(cmd_valid), 64'd0);
        q.push_back('{ir: m_ir, data: 38'h2_DEAD_BEEF, ts: m_ts});
        step();
        check("lat_push", 64'(cmd_valid), 64'd1);
        vs_udr = 1'b0;
        repeat (3) step();
        check_state("first");
        check("first_act", 64'(cmd_act), 64'b0100);
        do_pop();
        check_state("first_pop");
        do_pop();
        check_state("empty_pop");

        // Fill past capacity: fifth command is dropped and overflow sticks.
        for (int i = 0; i < 5; i++) begin
            do_udr(rnd_data(), 1'b0, 1'b0, 1'b0, 2'd0, 0);
            check_state("fill");
        end
        do_clr();
        check_state("clr");

        // Full queue with push and pop in the same cycle.
        do_udr(rnd_data(), 1'b1, 1'b0, 1'b0, 2'd0, 0);
        check_state("push_pop_full");
        // Full queue, drop coinciding with clear: clear wins.
        do_udr(rnd_data(), 1'b0, 1'b1, 1'b0, 2'd0, 0);
        check_state("clr_vs_drop");
        while (q.size() != 0) begin
            do_pop();
            check_state("drain");
        end

        // Simultaneous uir and udr: entry keeps the old IR.
        do_uir(IR_BREAK);
        do_udr(rnd_data(), 1'b0, 1'b0, 1'b1, IR_CTRL, 0);
        check_state("simul");
        do_udr(rnd_data(), 1'b0, 1'b0, 1'b0, 2'd0, 0);
        check("simul_level", 64'(fifo_level), 64'd2);

        // Held strobe yields exactly one command.
        do_udr(rnd_data(), 1'b0, 1'b0, 1'b0, 2'd0, 20);
        check_state("hold");

        // Reset mid-operation discards the queue.
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete(); m_ovf = 1'b0; m_ir = '0;
        check_state("mid_reset");

        // Randomised mix of operations.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0, 1, 2: do_udr(rnd_data(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 2'd0, 0);
                3:       do_uir(2'($urandom_range(0, 3)));
                4, 5:    do_pop();
                default: do_clr();
            endcase
            check_state("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
